// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and the pwm_capture decoder.
// The master drives the PWM line; the slave returns the recovered duty and status.
interface pwm_capture_if #(
  parameter int unsigned N = 8
) ();

  logic         pwm_in;
  logic [N-1:0] duty;
  logic         duty_valid;
  logic         period_err;
  logic         stuck;

  modport master (
    output pwm_in,
    input  duty,
    input  duty_valid,
    input  period_err,
    input  stuck
  );

  modport slave (
    input  pwm_in,
    output duty,
    output duty_valid,
    output period_err,
    output stuck
  );

endinterface

// File: rtl/pwm_capture.sv
// Recovers the N-bit duty value from a PWM line with a 2^N-cycle frame.
// Also reports wrong frame lengths and a line stuck low or high.
module pwm_capture #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           reset,
  pwm_capture_if.slave   bus
);

  localparam int unsigned PW = N + 2;
  localparam int unsigned HW = N + 1;
  localparam int unsigned IW = N + 1;

  localparam logic [PW-1:0] PCNT_FRAME = PW'(2**N);
  localparam logic [PW-1:0] PCNT_SAT   = '1;
  localparam logic [HW-1:0] HCNT_SAT   = '1;
  localparam logic [IW-1:0] ICNT_SAT   = IW'(2**N);
  localparam logic [IW-1:0] ICNT_LAST  = IW'(2**N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  logic          s1_q, s2_q, s3_q;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [N-1:0]  duty_q, duty_d;
  logic          duty_valid_q, duty_valid_d;
  logic          period_err_q, period_err_d;
  logic          stuck_q, stuck_d;

  logic rise_c, fall_c, edge_c, timeout_c;

  // Edge detection on the synchronized line; s3 is the previous s2 sample.
  assign rise_c    = s2_q & ~s3_q;
  assign fall_c    = ~s2_q & s3_q;
  assign edge_c    = rise_c | fall_c;
  assign timeout_c = ~edge_c & (icnt_q == ICNT_LAST);

  // Next-state, counters and report outputs.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    period_err_d = period_err_q;
    stuck_d      = stuck_q;
    pcnt_d       = pcnt_q;
    hcnt_d       = hcnt_q;
    icnt_d       = icnt_q;

    if (rise_c) begin
      pcnt_d = PW'(1);
    end else if (pcnt_q != PCNT_SAT) begin
      pcnt_d = pcnt_q + PW'(1);
    end

    if (rise_c) begin
      hcnt_d = HW'(1);
    end else if ((state_q == ST_HIGH) && !fall_c && (hcnt_q != HCNT_SAT)) begin
      hcnt_d = hcnt_q + HW'(1);
    end

    if (edge_c) begin
      icnt_d = '0;
    end else if (icnt_q != ICNT_SAT) begin
      icnt_d = icnt_q + IW'(1);
    end

    if (edge_c) begin
      stuck_d = 1'b0;
    end

    // Timeout fires only on the cycle icnt reaches saturation, so once per stuck interval.
    if (timeout_c) begin
      duty_d       = {N{s2_q}};
      stuck_d      = 1'b1;
      period_err_d = 1'b0;
      duty_valid_d = 1'b1;
      state_d      = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall_c) begin
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (rise_c) begin
            if (pcnt_q == PCNT_FRAME) begin
              duty_d       = hcnt_q[N-1:0];
              period_err_d = 1'b0;
            end else begin
              period_err_d = 1'b1;
            end
            duty_valid_d = 1'b1;
            stuck_d      = 1'b0;
            state_d      = ST_HIGH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // All state, including the synchronizer, clears on synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      hcnt_q       <= '0;
      icnt_q       <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      period_err_q <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      s1_q         <= bus.pwm_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      hcnt_q       <= hcnt_d;
      icnt_q       <= icnt_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      period_err_q <= period_err_d;
      stuck_q      <= stuck_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.period_err = period_err_q;
  assign bus.stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected reports with their
// cycle of arrival, a negedge monitor pops and compares on every duty_valid.
module tb_pwm_capture;

  localparam int unsigned N     = 8;
  localparam int unsigned FRAME = 256;

  typedef struct packed {
    logic [7:0]  duty;
    logic        err;
    logic        stuck;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cyc = '0;

  pwm_capture_if #(.N(N)) bus ();

  pwm_capture #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;

  // Reference model state: last reported duty and the previous complete pulse.
  logic [7:0]  mdl_duty;
  bit          have_prev;
  int unsigned prev_hi;
  int unsigned prev_per;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic e, input logic s, input logic [31:0] c);
    exp_t x;
    x.duty  = d;
    x.err   = e;
    x.stuck = s;
    x.cyc   = c;
    exp_q.push_back(x);
  endtask

  // A rise set at this negedge is processed at the third posedge from now.
  task automatic rise_report();
    if (have_prev) begin
      if (prev_per == FRAME) begin
        mdl_duty = 8'(prev_hi);
        push(mdl_duty, 1'b0, 1'b0, cyc + 32'd3);
      end else begin
        push(mdl_duty, 1'b1, 1'b0, cyc + 32'd3);
      end
    end
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    rise_report();
    bus.pwm_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
    have_prev = 1'b1;
    prev_hi   = hi;
    prev_per  = hi + lo;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_duty"},       32'(bus.duty),       32'd0);
    check({tag, "_duty_valid"}, 32'(bus.duty_valid), 32'd0);
    check({tag, "_period_err"}, 32'(bus.period_err), 32'd0);
    check({tag, "_stuck"},      32'(bus.stuck),      32'd0);
  endtask

  // Monitor: every duty_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.duty_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_duty_valid actual=1 required=0 (cycle %0d duty=%0d)", cyc, bus.duty);
      end else begin
        mon_e = exp_q.pop_front();
        check("report_cycle",      cyc,                    mon_e.cyc);
        check("report_duty",       32'(bus.duty),          32'(mon_e.duty));
        check("report_period_err", 32'(bus.period_err),    32'(mon_e.err));
        check("report_stuck",      32'(bus.stuck),         32'(mon_e.stuck));
      end
    end
  end

  initial begin
    logic [31:0] t;
    bus.pwm_in = 1'b0;
    reset      = 1'b1;
    mdl_duty   = 8'd0;
    have_prev  = 1'b0;
    prev_hi    = 0;
    prev_per   = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");

    // Constant low after reset: single timeout report at release edge 256.
    reset = 1'b0;
    push(8'd0, 1'b0, 1'b1, cyc + 32'd256);
    repeat (300) @(negedge clk);

    // Steady t_on = 50, then the duty extremes.
    repeat (4) pulse(50, 206);
    repeat (3) pulse(1, 255);
    repeat (3) pulse(255, 1);
    repeat (2) pulse(50, 206);

    // Stuck high from a rise: timeout 256 cycles after the rise is processed.
    rise_report();
    push(8'hFF, 1'b0, 1'b1, cyc + 32'd259);
    bus.pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    have_prev  = 1'b0;
    mdl_duty   = 8'hFF;
    bus.pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    check("stuck_before_fall", 32'(bus.stuck), 32'd1);
    @(negedge clk);
    check("stuck_after_fall", 32'(bus.stuck), 32'd0);
    repeat (10) @(negedge clk);

    // Fresh reset, then wrong period: duty keeps its reset value.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("reset2");
    mdl_duty  = 8'd0;
    have_prev = 1'b0;
    repeat (3) pulse(50, 150);
    repeat (3) pulse(50, 206);

    // Reset for one cycle during the last high cycle of a pulse.
    rise_report();
    bus.pwm_in = 1'b1;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    bus.pwm_in = 1'b0;
    check_outputs_zero("reset_mid_high");
    mdl_duty  = 8'd0;
    have_prev = 1'b0;
    repeat (206) @(negedge clk);
    repeat (3) pulse(50, 206);

    repeat (20) @(negedge clk);
    t = 32'(exp_q.size());
    check("pending_reports", t, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the sound generator's PWM DAC. Samples an asynchronous PWM line, measures high time and period between rising edges, and recovers the N-bit duty value the DAC was programmed with (t_on). It also detects a line stuck low or high, and flags periods that do not match the DAC frame length of 2^N cycles. It is used for loopback self-test and for decoding PWM from an external source.

## Interface
- N, default 8: duty width. The expected PWM period is 2^N clk cycles.
- clk  input  1  single system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- pwm_in  input  1  asynchronous PWM line.
- duty  output  N  last recovered duty value.
- duty_valid  output  1  one-cycle pulse when duty, period_err and stuck are updated.
- period_err  output  1  last measured period was not 2^N.
- stuck  output  1  no edge seen for 2^N cycles; held until the next edge.

## Operation
- **Synchronizer:** s1 <= pwm_in, s2 <= s1, s3 <= s2.
  - rise = s2 & ~s3; fall = ~s2 & s3; edge = rise | fall.
- **States:** IDLE, HIGH, LOW. Reset puts the block in IDLE.
- **pcnt (N+2 bits, saturating):** set to 1 on rise; otherwise incremented.
- **hcnt (N+1 bits, saturating):** set to 1 on rise; incremented in HIGH while not fall; frozen in LOW.
- **icnt (N+1 bits, saturating at 2^N):** cleared on edge; otherwise incremented.
- **IDLE:**
  - On rise: go to HIGH, no report.
  - A fall in IDLE only clears icnt.
- **HIGH:** on fall, go to LOW. hcnt then holds H, the number of high cycles.
- **LOW:** on rise, report and go to HIGH, starting a new measurement.
  - If pcnt == 2^N: duty <= hcnt[N-1:0], period_err <= 0.
  - Otherwise: period_err <= 1 and duty is unchanged.
  - In both cases duty_valid <= 1 and stuck <= 0.
- **Timeout** (icnt == 2^N-1 and no edge in this cycle, so icnt saturates to 2^N), in any state:
  - duty <= 0 if s2 == 0, else all ones.
  - stuck <= 1, period_err <= 0, duty_valid <= 1, state <= IDLE.
  - Fires once per stuck interval, because icnt saturates.
- **stuck** clears on the next edge.
  - The first rise after a timeout starts a new measurement only. No report is made until the following rise.
- **Precedence:** rise/fall handling and timeout are mutually exclusive by construction (timeout requires no edge).
- **Default:** duty_valid <= 0 every cycle not listed above.
- **Arithmetic:** all comparisons are unsigned. A period below 2^N or above 2^N, including saturated pcnt, sets period_err.

## Timing
- **Reset values:** duty = 0, duty_valid = 0, period_err = 0, stuck = 0.
  - s1, s2, s3, pcnt, hcnt and icnt are all 0; state is IDLE.
- **Reset mid-operation:** the measurement in progress is discarded. The first report needs two rises after reset is released, or a timeout.
- **Latency:** a pwm_in transition sampled at edge E becomes rise/fall during cycle E+1..E+2. The outputs update at edge E+2.
- **Report spacing:** one duty_valid every 2^N cycles for a steady, valid PWM signal.
- **Edge-spacing guarantee:** a DAC input with 0 < t_on < 2^N produces an edge at least every 2^N-1 cycles, so it never times out.
- **t_on = 0 from the DAC:** the line stays constant low and is reported through the timeout path as duty 0.
- **Outputs:** all registered, no combinational path from pwm_in.
- **Minimum pulse width:** 1-cycle high or low pulses must be measured correctly.

## Test plan
- **t_on = 50:** reset, then drive PWM with period 256 and 50 high cycles. The second rise gives duty_valid with duty = 50 and period_err = 0. Repeats every 256 cycles.
- **Extreme duty:** same as above with t_on = 1, then t_on = 255. Requires duty = 1, then duty = 255, with no period_err or stuck.
- **Constant low after reset:** exactly one duty_valid, at edge 256 after reset release, with duty = 0 and stuck = 1. No further pulses.
- **Stuck high:** after a valid duty = 50 report, hold pwm_in high from a rise. Requires one duty_valid 256 cycles after the rise is detected, with duty = 255 and stuck = 1. stuck clears at the next fall.
- **Wrong period:** PWM with period 200 and 50 high cycles. Requires duty_valid with period_err = 1 and duty retaining its previous value (0 after reset).
- **Reset mid-high:** assert reset for 1 cycle during a high phase. All outputs go to 0 at the next edge. No duty_valid until the second rise after reset, which reports the correct duty.
